uart_bridge: RTL and testbench

- Byte-stream command responder on the host side of the UART block.
- Consumes received bytes (UART DOUT/INT), decodes read/write commands, runs single transactions on a simple request/acknowledge bus, and returns a reply byte through the UART transmit port (DIN/OE/RDY).
- Lets an external PC peek and poke on-chip registers over the serial link.

---
 rtl/uart_bridge_if.sv | 27 ++
 rtl/uart_bridge.sv | 129 ++++++++++++
 tb/tb_uart_bridge.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_if.sv
// rtl/uart_bridge_if.sv - uart byte ports and request/acknowledge bus of the serial bridge
interface uart_bridge_if #(
    parameter int WADDR = 16
);
    logic [7:0]       rxdata;
    logic             rxint;
    logic [7:0]       txdata;
    logic             txoe;
    logic             txrdy;
    logic [WADDR-1:0] addr;
    logic [7:0]       wdata;
    logic             we;
    logic             re;
    logic [7:0]       rdata;
    logic             ack;
    logic             ovr;

    modport master (
        input  rxdata, rxint, txrdy, rdata, ack,
        output txdata, txoe, addr, wdata, we, re, ovr
    );

    modport slave (
        output rxdata, rxint, txrdy, rdata, ack,
        input  txdata, txoe, addr, wdata, we, re, ovr
    );
endinterface

// File: rtl/uart_bridge.sv
// rtl/uart_bridge.sv - serial peek/poke command responder driving a single-transaction register bus
module uart_bridge #(
    parameter int          WADDR   = 16,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input logic           clk,
    input logic           rst_n,
    uart_bridge_if.master u
);
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int          GW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_AHI,
        S_ALO,
        S_DAT,
        S_BUS,
        S_REPLY
    } state_t;

    state_t        state;
    logic          is_write;
    logic [GW-1:0] gap;
    logic          in_cmd;
    logic          gap_expired;

    assign in_cmd      = (state == S_AHI) || (state == S_ALO) || (state == S_DAT);
    // gap reaches TIMEOUT on this edge: the partial command is abandoned silently
    assign gap_expired = (TIMEOUT != 0) && in_cmd && !u.rxint && (gap == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            is_write <= 1'b0;
            gap      <= '0;
            u.txdata <= 8'h00;
            u.txoe   <= 1'b0;
            u.addr   <= '0;
            u.wdata  <= 8'h00;
            u.we     <= 1'b0;
            u.re     <= 1'b0;
            u.ovr    <= 1'b0;
        end else begin
            u.txoe <= 1'b0;
            u.ovr  <= 1'b0;

            if (in_cmd && !u.rxint && !gap_expired) begin
                gap <= gap + 1'b1;
            end else begin
                gap <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (u.rxint) begin
                        if ((u.rxdata == CMD_RD) || (u.rxdata == CMD_WR)) begin
                            is_write <= (u.rxdata == CMD_WR);
                            state    <= S_AHI;
                        end else begin
                            u.txdata <= RSP_NAK;
                            state    <= S_REPLY;
                        end
                    end
                end
                S_AHI: begin
                    if (u.rxint) begin
                        u.addr[WADDR-1 -: 8] <= u.rxdata;
                        state                <= S_ALO;
                    end else if (gap_expired) begin
                        state <= S_IDLE;
                    end
                end
                S_ALO: begin
                    if (u.rxint) begin
                        u.addr[7:0] <= u.rxdata;
                        if (is_write) begin
                            state <= S_DAT;
                        end else begin
                            u.re  <= 1'b1;
                            state <= S_BUS;
                        end
                    end else if (gap_expired) begin
                        state <= S_IDLE;
                    end
                end
                S_DAT: begin
                    if (u.rxint) begin
                        u.wdata <= u.rxdata;
                        u.we    <= 1'b1;
                        state   <= S_BUS;
                    end else if (gap_expired) begin
                        state <= S_IDLE;
                    end
                end
                S_BUS: begin
                    if (u.rxint) begin
                        u.ovr <= 1'b1;
                    end
                    if (u.ack) begin
                        u.we     <= 1'b0;
                        u.re     <= 1'b0;
                        u.txdata <= is_write ? RSP_ACK : u.rdata;
                        state    <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    // a byte landing on the TXOE cycle is still dropped; IDLE starts next cycle
                    if (u.rxint) begin
                        u.ovr <= 1'b1;
                    end
                    if (u.txrdy) begin
                        u.txoe <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bridge.sv
// tb/tb_uart_bridge.sv - self-checking bench for uart_bridge: vector table, corner sequences, random commands
module tb_uart_bridge;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_bridge_if #(.WADDR(16)) u_if ();

    uart_bridge #(.WADDR(16), .TIMEOUT(100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .u    (u_if)
    );

    typedef struct {
        logic [7:0]  b [4];
        int          n;
        logic [7:0]  reply;
        bit          is_wr;
        bit          is_rd;
        logic [15:0] a;
        logic [7:0]  wd;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    int          n_txoe = 0, n_ovr = 0, n_we = 0, n_re = 0, held_err = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [15:0] last_addr = 16'h0000;
    logic [7:0]  last_wdata = 8'h00;
    int          s_txoe, s_ovr, s_we, s_re, s_held;

    logic [7:0] bus_mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];
    int   ack_delay = 3;
    int   cnt = 0;
    logic ack_hold = 1'b0;

    // monitor first, then the bus responder, all on the falling edge
    always @(negedge clk) begin
        if (u_if.txoe) begin n_txoe++; last_tx = u_if.txdata; end
        if (u_if.ovr) n_ovr++;
        if (u_if.we) begin n_we++; last_addr = u_if.addr; last_wdata = u_if.wdata; end
        if (u_if.re) begin n_re++; last_addr = u_if.addr; end
        if (!rst_n) begin
            u_if.ack = 1'b0;
            cnt = 0;
        end else if (u_if.ack) begin
            if (u_if.we || u_if.re) held_err++;
            u_if.ack = 1'b0;
            cnt = 0;
        end else if ((u_if.we || u_if.re) && !ack_hold) begin
            if (cnt >= ack_delay) begin
                u_if.ack = 1'b1;
                if (u_if.we) bus_mem[u_if.addr] = u_if.wdata;
                else u_if.rdata = bus_mem.exists(u_if.addr) ? bus_mem[u_if.addr] : 8'h00;
            end else begin
                cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.rxdata = b;
        u_if.rxint  = 1'b1;
        tick;
        u_if.rxint  = 1'b0;
    endtask

    task automatic snap;
        s_txoe = n_txoe; s_ovr = n_ovr; s_we = n_we; s_re = n_re; s_held = held_err;
    endtask

    task automatic wait_reply;
        for (int i = 0; i < 300 && n_txoe == s_txoe; i++) tick;
        chk("reply_seen", 32'(n_txoe != s_txoe), 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] bq [4], input int n, input int gap);
        snap;
        for (int i = 0; i < n; i++) begin
            send_byte(bq[i]);
            if (i < n - 1) idle(gap);
        end
        wait_reply;
        idle(2);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n,
                                input logic [7:0] r, input bit w, input bit rd,
                                input logic [15:0] a, input logic [7:0] wd);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.n = n; v.reply = r; v.is_wr = w; v.is_rd = rd; v.a = a; v.wd = wd;
        return v;
    endfunction

    vec_t       tbl [9];
    logic [7:0] bq [4];

    initial begin
        u_if.rxdata = 8'h00;
        u_if.rxint  = 1'b0;
        u_if.txrdy  = 1'b1;
        bus_mem[16'h0010] = 8'h5A;
        bus_mem[16'h0001] = 8'hC3;
        bus_mem[16'h0030] = 8'h3C;

        tbl[0] = mk(8'h57, 8'h12, 8'h34, 8'hAB, 4, 8'h4B, 1, 0, 16'h1234, 8'hAB);
        tbl[1] = mk(8'h52, 8'h00, 8'h10, 8'h00, 3, 8'h5A, 0, 1, 16'h0010, 8'h00);
        tbl[2] = mk(8'h41, 8'h00, 8'h00, 8'h00, 1, 8'h15, 0, 0, 16'h0000, 8'h00);
        tbl[3] = mk(8'h52, 8'h12, 8'h34, 8'h00, 3, 8'hAB, 0, 1, 16'h1234, 8'h00);
        tbl[4] = mk(8'h57, 8'hFF, 8'hFF, 8'h00, 4, 8'h4B, 1, 0, 16'hFFFF, 8'h00);
        tbl[5] = mk(8'h52, 8'hFF, 8'hFF, 8'h00, 3, 8'h00, 0, 1, 16'hFFFF, 8'h00);
        tbl[6] = mk(8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h15, 0, 0, 16'h0000, 8'h00);
        tbl[7] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 1, 8'h15, 0, 0, 16'h0000, 8'h00);
        tbl[8] = mk(8'h52, 8'h00, 8'h10, 8'h00, 3, 8'h5A, 0, 1, 16'h0010, 8'h00);

        idle(3);
        chk("rst_txdata", 32'(u_if.txdata), 32'h0);
        chk("rst_txoe",   32'(u_if.txoe),   32'h0);
        chk("rst_addr",   32'(u_if.addr),   32'h0);
        chk("rst_wdata",  32'(u_if.wdata),  32'h0);
        chk("rst_we",     32'(u_if.we),     32'h0);
        chk("rst_re",     32'(u_if.re),     32'h0);
        chk("rst_ovr",    32'(u_if.ovr),    32'h0);
        rst_n = 1'b1;
        tick;

        ack_delay = 3;
        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].b, tbl[i].n, 0);
            chk($sformatf("tbl%0d_reply", i), 32'(last_tx), 32'(tbl[i].reply));
            chk($sformatf("tbl%0d_txoe_count", i), 32'(n_txoe - s_txoe), 32'd1);
            chk($sformatf("tbl%0d_we_cycles", i), 32'(n_we - s_we), tbl[i].is_wr ? 32'(ack_delay + 1) : 32'd0);
            chk($sformatf("tbl%0d_re_cycles", i), 32'(n_re - s_re), tbl[i].is_rd ? 32'(ack_delay + 1) : 32'd0);
            chk($sformatf("tbl%0d_held_past_ack", i), 32'(held_err - s_held), 32'd0);
            if (tbl[i].is_wr || tbl[i].is_rd) chk($sformatf("tbl%0d_addr", i), 32'(last_addr), 32'(tbl[i].a));
            if (tbl[i].is_wr) chk($sformatf("tbl%0d_wdata", i), 32'(last_wdata), 32'(tbl[i].wd));
        end

        // 99 idle cycles between bytes is still inside the window
        ack_delay = 1;
        bq[0] = 8'h57; bq[1] = 8'h22; bq[2] = 8'h22; bq[3] = 8'h77;
        run_cmd(bq, 4, 99);
        chk("gap99_reply", 32'(last_tx), 32'h4B);
        chk("gap99_addr",  32'(last_addr), 32'h2222);
        chk("gap99_wdata", 32'(last_wdata), 32'h77);

        // 100 idle cycles aborts; partial address stays
        snap;
        send_byte(8'h57);
        send_byte(8'h12);
        idle(100);
        chk("tmo_txoe", 32'(n_txoe - s_txoe), 32'd0);
        chk("tmo_we",   32'(n_we - s_we), 32'd0);
        chk("tmo_partial_addr", 32'(u_if.addr), 32'h1222);
        bq[0] = 8'h52; bq[1] = 8'h00; bq[2] = 8'h01; bq[3] = 8'h00;
        run_cmd(bq, 3, 0);
        chk("tmo_next_reply", 32'(last_tx), 32'hC3);
        chk("tmo_next_addr",  32'(last_addr), 32'h0001);
        chk("tmo_next_no_we", 32'(n_we - s_we), 32'd0);

        // overrun during BUS
        ack_hold = 1'b1;
        snap;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h30);
        idle(3);
        chk("ovr_re_high", 32'(u_if.re), 32'd1);
        send_byte(8'hFF);
        idle(2);
        chk("ovr_pulse_cycles", 32'(n_ovr - s_ovr), 32'd1);
        chk("ovr_re_still", 32'(u_if.re), 32'd1);
        chk("ovr_no_txoe", 32'(n_txoe - s_txoe), 32'd0);
        ack_hold = 1'b0;
        wait_reply;
        chk("ovr_reply", 32'(last_tx), 32'h3C);
        chk("ovr_addr",  32'(last_addr), 32'h0030);
        idle(2);

        // TX backpressure in REPLY, plus a dropped byte there
        u_if.txrdy = 1'b0;
        snap;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h40); send_byte(8'h99);
        for (int i = 0; i < 50 && !((n_we > s_we) && !u_if.we); i++) tick;
        chk("bp_write_done", 32'((n_we > s_we) && !u_if.we), 32'd1);
        idle(50);
        chk("bp_no_txoe", 32'(n_txoe - s_txoe), 32'd0);
        send_byte(8'hEE);
        idle(1);
        chk("bp_reply_ovr", 32'(n_ovr - s_ovr), 32'd1);
        u_if.txrdy = 1'b1;
        wait_reply;
        chk("bp_reply", 32'(last_tx), 32'h4B);
        idle(5);
        chk("bp_txoe_once", 32'(n_txoe - s_txoe), 32'd1);
        chk("bp_txdata_hold", 32'(u_if.txdata), 32'h4B);

        // asynchronous reset during a read
        ack_hold = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        idle(2);
        chk("rstmid_re_before", 32'(u_if.re), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_re_async", 32'(u_if.re), 32'd0);
        tick; tick;
        rst_n = 1'b1;
        ack_hold = 1'b0;
        snap;
        idle(20);
        chk("rstmid_no_txoe", 32'(n_txoe - s_txoe), 32'd0);
        chk("rstmid_no_re",   32'(n_re - s_re), 32'd0);
        bq[0] = 8'h52; bq[1] = 8'h00; bq[2] = 8'h10; bq[3] = 8'h00;
        run_cmd(bq, 3, 0);
        chk("rstmid_next_reply", 32'(last_tx), 32'h5A);

        // random commands against a peek/poke memory model
        for (int k = 0; k < 40; k++) begin
            int          kind, n;
            logic [15:0] a;
            logic [7:0]  d, exp_r;
            bit          wr, rd;
            kind = $urandom_range(0, 9);
            a    = 16'h0100 + 16'($urandom_range(0, 7));
            d    = 8'($urandom_range(0, 255));
            wr   = (kind >= 4 && kind < 8);
            rd   = (kind < 4);
            ack_delay = $urandom_range(0, 4);
            bq[1] = a[15:8]; bq[2] = a[7:0]; bq[3] = d;
            if (rd) begin
                bq[0] = 8'h52; n = 3;
                exp_r = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
            end else if (wr) begin
                bq[0] = 8'h57; n = 4;
                ref_mem[a] = d;
                exp_r = 8'h4B;
            end else begin
                bq[0] = 8'($urandom_range(0, 255));
                if (bq[0] == 8'h52 || bq[0] == 8'h57) bq[0] = 8'h00;
                n = 1;
                exp_r = 8'h15;
            end
            run_cmd(bq, n, $urandom_range(0, 3));
            chk($sformatf("rnd%0d_reply", k), 32'(last_tx), 32'(exp_r));
            chk($sformatf("rnd%0d_we_cycles", k), 32'(n_we - s_we), wr ? 32'(ack_delay + 1) : 32'd0);
            chk($sformatf("rnd%0d_re_cycles", k), 32'(n_re - s_re), rd ? 32'(ack_delay + 1) : 32'd0);
            if (wr || rd) chk($sformatf("rnd%0d_addr", k), 32'(last_addr), 32'(a));
            if (wr) chk($sformatf("rnd%0d_wdata", k), 32'(last_wdata), 32'(d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
